// File: rtl/sarray_bottom_deskew_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sarray_bottom_deskew_regs                                  |
// | Description : Output de-skew for the systolic array bottom edge; column  |
// |               i is delayed COLS-1-i cycles, aligned rows go to a FWFT    |
// |               FIFO. Optional count check: SARRAY_DESKEW_CNT_CHECK_EN.    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module sarray_bottom_deskew_regs #(
    parameter int COLS       = 4,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [COLS-1:0]               col_valid_i,
    input  logic [COLS*CNT_W-1:0]         col_cnt_i,
    input  logic [COLS*DATA_W-1:0]        col_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [CNT_W-1:0]              out_cnt_o,
    output logic [COLS*DATA_W-1:0]        out_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          skew_err_o,
    output logic                          ovf_err_o,
    output logic                          cnt_err_o
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w  = c_addr_w + 1;
`ifdef SARRAY_DESKEW_CNT_CHECK_EN
    localparam int c_cnt_cols = COLS;
`else
    localparam int c_cnt_cols = 1;
`endif
    localparam logic [c_lvl_w-1:0] c_depth = c_lvl_w'(FIFO_DEPTH);

    logic [COLS-1:0]             w_dly_valid;
    logic [COLS*DATA_W-1:0]      w_dly_data;
    logic [c_cnt_cols*CNT_W-1:0] w_dly_cnt;
    logic [COLS-1:0]             w_chain_busy;

    logic [COLS-1:0]             r_al_valid;
    logic [COLS*DATA_W-1:0]      r_al_data;
    logic [c_cnt_cols*CNT_W-1:0] r_al_cnt;

    logic [COLS*DATA_W-1:0]      r_mem_data [FIFO_DEPTH];
    logic [CNT_W-1:0]            r_mem_cnt  [FIFO_DEPTH];
    logic [c_addr_w-1:0]         r_wr_ptr;
    logic [c_addr_w-1:0]         r_rd_ptr;
    logic [c_lvl_w-1:0]          r_level;
    logic                        r_skew_err;
    logic                        r_ovf_err;

    logic w_all;
    logic w_mixed;
    logic w_cnt_ok;
    logic w_cand;
    logic w_pop;
    logic w_room;
    logic w_push;

    for (genvar i = 0; i < COLS; i++) begin : g_col
        localparam int c_stages = COLS - 1 - i;

        if (c_stages > 0) begin : g_dly
            logic [c_stages-1:0] r_v;
            logic [DATA_W-1:0]   r_d [c_stages];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= '0;
                end else begin
                    r_v[0] <= col_valid_i[i];
                    for (int k = 1; k < c_stages; k++) begin
                        r_v[k] <= r_v[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_d[0] <= col_data_i[i*DATA_W +: DATA_W];
                for (int k = 1; k < c_stages; k++) begin
                    r_d[k] <= r_d[k-1];
                end
            end

            assign w_dly_valid[i]                   = r_v[c_stages-1];
            assign w_dly_data[i*DATA_W +: DATA_W]   = r_d[c_stages-1];
            assign w_chain_busy[i]                  = |r_v;
        end else begin : g_nodly
            assign w_dly_valid[i]                   = col_valid_i[i];
            assign w_dly_data[i*DATA_W +: DATA_W]   = col_data_i[i*DATA_W +: DATA_W];
            assign w_chain_busy[i]                  = 1'b0;
        end

        // Counts ride the same delay as data, but only for columns that are compared.
        if (i < c_cnt_cols) begin : g_cnt
            if (c_stages > 0) begin : g_cdly
                logic [CNT_W-1:0] r_c [c_stages];

                always_ff @(posedge clk) begin
                    r_c[0] <= col_cnt_i[i*CNT_W +: CNT_W];
                    for (int k = 1; k < c_stages; k++) begin
                        r_c[k] <= r_c[k-1];
                    end
                end

                assign w_dly_cnt[i*CNT_W +: CNT_W] = r_c[c_stages-1];
            end else begin : g_cnodly
                assign w_dly_cnt[i*CNT_W +: CNT_W] = col_cnt_i[i*CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_al_valid <= '0;
        end else begin
            r_al_valid <= w_dly_valid;
        end
    end

    always_ff @(posedge clk) begin
        r_al_data <= w_dly_data;
        r_al_cnt  <= w_dly_cnt;
    end

    assign w_all   = &r_al_valid;
    assign w_mixed = (|r_al_valid) & ~w_all;

`ifdef SARRAY_DESKEW_CNT_CHECK_EN
    logic r_cnt_err;

    always_comb begin
        w_cnt_ok = 1'b1;
        for (int i = 1; i < c_cnt_cols; i++) begin
            if (r_al_cnt[i*CNT_W +: CNT_W] != r_al_cnt[CNT_W-1:0]) begin
                w_cnt_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_err <= 1'b0;
        end else if (w_all & ~w_cnt_ok) begin
            r_cnt_err <= 1'b1;
        end
    end

    assign cnt_err_o = r_cnt_err;
`else
    logic w_unused_cnt;

    assign w_unused_cnt = ^col_cnt_i[COLS*CNT_W-1:CNT_W];
    assign w_cnt_ok     = 1'b1;
    assign cnt_err_o    = 1'b0;
`endif

    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign w_cand = w_all & w_cnt_ok;
    assign w_pop  = out_valid_o & out_ready_i;
    assign w_room = (r_level != c_depth) | w_pop;
    assign w_push = w_cand & w_room;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= r_al_data;
            r_mem_cnt[r_wr_ptr]  <= r_al_cnt[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_skew_err <= 1'b0;
            r_ovf_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_mixed) begin
                r_skew_err <= 1'b1;
            end
            if (w_cand & ~w_room) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign out_valid_o = (r_level != '0);
    assign out_data_o  = r_mem_data[r_rd_ptr];
    assign out_cnt_o   = r_mem_cnt[r_rd_ptr];
    assign level_o     = r_level;
    assign busy_o      = (|w_chain_busy) | (|r_al_valid) | out_valid_o;
    assign skew_err_o  = r_skew_err;
    assign ovf_err_o   = r_ovf_err;

endmodule
`default_nettype wire
